fetch_source: RTL and testbench

FETCH_SOURCE -- requirements
Module: fetch_source

---
 rtl/fetch_source.sv | 100 ++++++++++
 tb/tb_fetch_source.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/fetch_source.sv
// Instruction fetch source: drives SRAM requests and presents one slot downstream.
// Optional FETCH_ADEL_CHECK_EN flags misaligned fetches instead of issuing them.
module fetch_source #(
    parameter logic [31:0] RESET_PC = 32'hBFC00000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        post_allowin,
    output logic        goon_valid,
    output logic [31:0] pc,
    output logic [31:0] instruction,
    output logic        sig_adel,
    input  logic        br_taken,
    input  logic [31:0] br_target,
    input  logic        exc_flush,
    input  logic [31:0] exc_target,
    output logic        inst_sram_en,
    output logic [31:0] inst_sram_addr,
    input  logic [31:0] inst_sram_rdata
);

    logic [31:0] fetch_pc_q, fetch_pc_d;
    logic        out_valid_q, out_valid_d;
    logic [31:0] out_pc_q, out_pc_d;
    logic        buf_valid_q, buf_valid_d;
    logic [31:0] buf_data_q, buf_data_d;
    logic        out_adel_q, out_adel_d;

    logic        redirect;
    logic [31:0] target;
    logic        issue;
    logic        adel_hit;

    always_comb begin
        redirect = exc_flush | br_taken;
        target   = exc_flush ? exc_target : br_target;
        issue    = !redirect && (!out_valid_q || post_allowin);
`ifdef FETCH_ADEL_CHECK_EN
        adel_hit = (fetch_pc_q[1:0] != 2'b00);
`else
        adel_hit = 1'b0;
`endif

        fetch_pc_d  = fetch_pc_q;
        out_valid_d = out_valid_q;
        out_pc_d    = out_pc_q;
        buf_valid_d = buf_valid_q;
        buf_data_d  = buf_data_q;
        out_adel_d  = out_adel_q;

        if (redirect) begin
            fetch_pc_d  = target;
            out_valid_d = 1'b0;
            buf_valid_d = 1'b0;
            out_adel_d  = 1'b0;
        end else if (issue) begin
            fetch_pc_d  = fetch_pc_q + 32'd4;
            out_valid_d = 1'b1;
            out_pc_d    = fetch_pc_q;
            buf_valid_d = 1'b0;
            out_adel_d  = adel_hit;
        end else if (out_valid_q && !post_allowin && !buf_valid_q) begin
            // SRAM data is only valid for one cycle; capture it while the slot stalls
            buf_data_d  = inst_sram_rdata;
            buf_valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_pc_q  <= RESET_PC;
            out_valid_q <= 1'b0;
            out_pc_q    <= 32'd0;
            buf_valid_q <= 1'b0;
            buf_data_q  <= 32'd0;
            out_adel_q  <= 1'b0;
        end else begin
            fetch_pc_q  <= fetch_pc_d;
            out_valid_q <= out_valid_d;
            out_pc_q    <= out_pc_d;
            buf_valid_q <= buf_valid_d;
            buf_data_q  <= buf_data_d;
            out_adel_q  <= out_adel_d;
        end
    end

    assign inst_sram_en   = issue && !reset && !adel_hit;
    assign inst_sram_addr = fetch_pc_q;
    assign goon_valid     = out_valid_q;
    assign pc             = out_pc_q;
`ifdef FETCH_ADEL_CHECK_EN
    assign sig_adel       = out_adel_q;
    assign instruction    = out_adel_q ? 32'd0 :
                            (buf_valid_q ? buf_data_q : inst_sram_rdata);
`else
    assign sig_adel       = 1'b0;
    assign instruction    = buf_valid_q ? buf_data_q : inst_sram_rdata;
`endif

endmodule

// File: tb/tb_fetch_source.sv
// Self-checking bench for fetch_source: directed table, corner sequences, random run vs. a slot-level model.
module tb_fetch_source;

    localparam logic [31:0] RESET_PC = 32'hBFC00000;
`ifdef FETCH_ADEL_CHECK_EN
    localparam bit ADEL = 1'b1;
`else
    localparam bit ADEL = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        post_allowin;
    logic        goon_valid;
    logic [31:0] pc;
    logic [31:0] instruction;
    logic        sig_adel;
    logic        br_taken;
    logic [31:0] br_target;
    logic        exc_flush;
    logic [31:0] exc_target;
    logic        inst_sram_en;
    logic [31:0] inst_sram_addr;
    logic [31:0] inst_sram_rdata;

    always #5 clk = ~clk;

    fetch_source #(.RESET_PC(RESET_PC)) dut (
        .clk(clk), .reset(reset), .post_allowin(post_allowin),
        .goon_valid(goon_valid), .pc(pc), .instruction(instruction), .sig_adel(sig_adel),
        .br_taken(br_taken), .br_target(br_target), .exc_flush(exc_flush), .exc_target(exc_target),
        .inst_sram_en(inst_sram_en), .inst_sram_addr(inst_sram_addr), .inst_sram_rdata(inst_sram_rdata)
    );

    int tests = 0;
    int fails = 0;

    // Model: the fetch pointer plus the slot currently shown downstream.
    logic [31:0] m_fetch = RESET_PC;
    logic        m_valid = 1'b0;
    logic [31:0] m_spc   = 32'd0;
    logic        m_adel  = 1'b0;
    logic        prev_req  = 1'b0;
    logic [31:0] prev_addr = 32'd0;

    logic        obs_valid, obs_en, obs_adel;
    logic [31:0] obs_pc, obs_addr, obs_inst;

    function automatic logic [31:0] mem(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'hA5C3_0F1E;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
        end
    endtask

    // One cycle: drive inputs just after posedge, compare on negedge, advance model.
    task automatic step(input logic r, input logic pa, input logic br, input logic [31:0] bt,
                        input logic ex, input logic [31:0] et);
        logic redir, iss, mis, exp_en;
        logic [31:0] tgt;
        #1;
        reset = r; post_allowin = pa; br_taken = br; br_target = bt;
        exc_flush = ex; exc_target = et;
        inst_sram_rdata = prev_req ? mem(prev_addr) : $urandom;
        @(negedge clk);
        obs_valid = goon_valid; obs_pc = pc; obs_addr = inst_sram_addr;
        obs_en = inst_sram_en; obs_inst = instruction; obs_adel = sig_adel;

        redir  = ex | br;
        tgt    = ex ? et : bt;
        iss    = !r && !redir && (!m_valid || pa);
        mis    = ADEL && (m_fetch[1:0] != 2'b00);
        exp_en = iss && !mis;

        check("sram_en", {31'd0, obs_en}, {31'd0, exp_en});
        check("sram_addr", obs_addr, m_fetch);
        check("goon_valid", {31'd0, obs_valid}, {31'd0, m_valid});
        if (m_valid) begin
            check("slot_pc", obs_pc, m_spc);
            check("slot_inst", obs_inst, (ADEL && m_adel) ? 32'd0 : mem(m_spc));
            check("slot_adel", {31'd0, obs_adel}, {31'd0, ADEL && m_adel});
        end

        prev_req  = exp_en;
        prev_addr = m_fetch;
        if (r) begin
            m_fetch = RESET_PC; m_valid = 1'b0; m_spc = 32'd0; m_adel = 1'b0;
        end else if (redir) begin
            m_fetch = tgt; m_valid = 1'b0; m_adel = 1'b0;
        end else if (iss) begin
            m_spc = m_fetch; m_valid = 1'b1; m_adel = mis; m_fetch = m_fetch + 32'd4;
        end
        @(posedge clk);
    endtask

    typedef struct {
        logic        rst, pa, br, ex;
        logic [31:0] bt, et;
        logic        e_valid;
        logic [31:0] e_pc, e_addr;
        logic        e_en;
    } vec_t;

    vec_t vt[11];

    initial begin
        vt[0]  = '{1, 1, 0, 0, 32'h0,          32'h0,          0, 32'h0,          32'hBFC00000, 0};
        vt[1]  = '{0, 1, 0, 0, 32'h0,          32'h0,          0, 32'h0,          32'hBFC00000, 1};
        vt[2]  = '{0, 1, 0, 0, 32'h0,          32'h0,          1, 32'hBFC00000, 32'hBFC00004, 1};
        vt[3]  = '{0, 1, 1, 0, 32'hBFC00100, 32'h0,          1, 32'hBFC00004, 32'hBFC00008, 0};
        vt[4]  = '{0, 1, 0, 0, 32'h0,          32'h0,          0, 32'hBFC00004, 32'hBFC00100, 1};
        vt[5]  = '{0, 1, 1, 1, 32'hBFC00100, 32'hBFC00380, 1, 32'hBFC00100, 32'hBFC00104, 0};
        vt[6]  = '{0, 1, 0, 0, 32'h0,          32'h0,          0, 32'hBFC00100, 32'hBFC00380, 1};
        vt[7]  = '{0, 0, 0, 0, 32'h0,          32'h0,          1, 32'hBFC00380, 32'hBFC00384, 0};
        vt[8]  = '{0, 0, 0, 0, 32'h0,          32'h0,          1, 32'hBFC00380, 32'hBFC00384, 0};
        vt[9]  = '{0, 1, 0, 0, 32'h0,          32'h0,          1, 32'hBFC00380, 32'hBFC00384, 1};
        vt[10] = '{0, 1, 0, 0, 32'h0,          32'h0,          1, 32'hBFC00384, 32'hBFC00388, 1};

        reset = 1'b1; post_allowin = 1'b0; br_taken = 1'b0; br_target = 32'd0;
        exc_flush = 1'b0; exc_target = 32'd0; inst_sram_rdata = 32'd0;
        repeat (2) @(posedge clk);

        for (int i = 0; i < 11; i++) begin
            step(vt[i].rst, vt[i].pa, vt[i].br, vt[i].bt, vt[i].ex, vt[i].et);
            check($sformatf("vec%0d_valid", i), {31'd0, obs_valid}, {31'd0, vt[i].e_valid});
            check($sformatf("vec%0d_pc", i), obs_pc, vt[i].e_pc);
            check($sformatf("vec%0d_addr", i), obs_addr, vt[i].e_addr);
            check($sformatf("vec%0d_en", i), {31'd0, obs_en}, {31'd0, vt[i].e_en});
        end

        // Address wrap at the top of the address space
        step(0, 1, 1, 32'hFFFFFFF8, 0, 32'h0);
        step(0, 1, 0, 32'h0, 0, 32'h0);
        step(0, 1, 0, 32'h0, 0, 32'h0);
        check("wrap_addr_fffffffc", obs_addr, 32'hFFFFFFFC);
        step(0, 1, 0, 32'h0, 0, 32'h0);
        check("wrap_addr_zero", obs_addr, 32'h00000000);
        check("wrap_slot_pc", obs_pc, 32'hFFFFFFFC);

        // Misaligned redirect target
        step(0, 1, 1, 32'hBFC00102, 0, 32'h0);
        step(0, 1, 0, 32'h0, 0, 32'h0);
        check("mis_addr", obs_addr, 32'hBFC00102);
        check("mis_en", {31'd0, obs_en}, {31'd0, !ADEL});
        step(0, 0, 0, 32'h0, 0, 32'h0);
        check("mis_slot_pc", obs_pc, 32'hBFC00102);
        check("mis_adel", {31'd0, obs_adel}, {31'd0, ADEL});
        check("mis_inst", obs_inst, ADEL ? 32'd0 : mem(32'hBFC00102));

        // Held redirect, then reset in mid-stream while stalled
        step(0, 0, 1, 32'hBFC00200, 0, 32'h0);
        step(0, 0, 1, 32'hBFC00300, 0, 32'h0);
        check("held_redir_valid", {31'd0, obs_valid}, 32'd0);
        check("held_redir_en", {31'd0, obs_en}, 32'd0);
        step(0, 0, 0, 32'h0, 0, 32'h0);
        check("held_redir_addr", obs_addr, 32'hBFC00300);
        step(0, 0, 0, 32'h0, 0, 32'h0);
        step(1, 0, 0, 32'h0, 0, 32'h0);
        step(0, 0, 0, 32'h0, 0, 32'h0);
        check("midreset_valid", {31'd0, obs_valid}, 32'd0);
        check("midreset_addr", obs_addr, RESET_PC);
        check("midreset_en", {31'd0, obs_en}, 32'd1);

        for (int n = 0; n < 400; n++) begin
            logic r, pa, br, ex;
            logic [31:0] bt, et;
            r  = ($urandom_range(0, 99) < 2);
            pa = ($urandom_range(0, 99) < 70);
            br = ($urandom_range(0, 99) < 10);
            ex = ($urandom_range(0, 99) < 5);
            bt = {$urandom_range(0, 65535), 14'd0, 2'(($urandom_range(0, 9) == 0) ? 2 : 0)};
            et = {$urandom_range(0, 65535), 16'd0} | 32'h180;
            step(r, pa, br, bt, ex, et);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
